approx_acc_sub: RTL and testbench

Sequential approximate accumulate/subtract unit for the systolic array's partial-sum path. It folds a fixed-length stream of signed operands into one signed result, adding or subtracting each operand. Every step uses the team's truncated-LSB approximate addition: the low `IGNORE_BIT` bits carry nothing, and the result's low bits are forced to 1. Operands arrive on a valid/ready stream. The finished result is offered on a second valid/ready stream, together with a per-frame overflow flag.

---
 rtl/approx_acc_sub_if.sv | 24 ++
 rtl/approx_acc_sub.sv | 84 ++++++++
 tb/tb_approx_acc_sub.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_acc_sub_if.sv
// rtl/approx_acc_sub_if.sv - operand and result valid/ready streams for approx_acc_sub
interface approx_acc_sub_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/approx_acc_sub.sv
// rtl/approx_acc_sub.sv - frame accumulate/subtract with truncated-LSB approximate adder
module approx_acc_sub #(
    parameter int IGNORE_BIT = 0,
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int COUNT      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    approx_acc_sub_if.slave  bus
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [ACC_WIDTH-1:0] LOW_MASK = ACC_WIDTH'((64'd1 << IGNORE_BIT) - 64'd1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    logic signed [WIDTH-1:0]     d_s;
    logic signed [ACC_WIDTH-1:0] x_s;
    logic [ACC_WIDTH-1:0]        x;
    logic [ACC_WIDTH-1:0]        sum;
    logic [ACC_WIDTH-1:0]        step;
    logic                        step_ovf;

    assign d_s = bus.in_data;
    assign x_s = d_s;

    // Masking the low field of both operands to zero means no carry can leave it,
    // so the full-width add yields exactly the H-bit upper-field sum.
    always_comb begin
        x        = bus.in_sub ? (~x_s + ACC_WIDTH'(1)) : x_s;
        sum      = (acc & ~LOW_MASK) + (x & ~LOW_MASK);
        step     = sum | LOW_MASK;
        step_ovf = (acc[ACC_WIDTH-1] == x[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= ST_ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= step;
                        ovf <= ovf | step_ovf;
                        if (cnt == CNT_LAST) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_approx_acc_sub.sv
// tb/tb_approx_acc_sub.sv - scoreboard bench for approx_acc_sub over three configurations
module tb_approx_acc_sub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clear;
    logic       vld_a, sub_a, ordy_a;
    logic [7:0] dat_a;
    logic       vld_b, sub_b, ordy_b;
    logic [11:0] dat_b;

    approx_acc_sub_if #(.WIDTH(8),  .ACC_WIDTH(12)) if0 ();
    approx_acc_sub_if #(.WIDTH(8),  .ACC_WIDTH(12)) if1 ();
    approx_acc_sub_if #(.WIDTH(12), .ACC_WIDTH(12)) if2 ();

    assign if0.in_valid = vld_a;  assign if0.in_data = dat_a;  assign if0.in_sub = sub_a;  assign if0.out_ready = ordy_a;
    assign if1.in_valid = vld_a;  assign if1.in_data = dat_a;  assign if1.in_sub = sub_a;  assign if1.out_ready = ordy_a;
    assign if2.in_valid = vld_b;  assign if2.in_data = dat_b;  assign if2.in_sub = sub_b;  assign if2.out_ready = ordy_b;

    approx_acc_sub #(.IGNORE_BIT(2), .WIDTH(8), .ACC_WIDTH(12), .COUNT(4))
        d0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0.slave));
    approx_acc_sub #(.IGNORE_BIT(0), .WIDTH(8), .ACC_WIDTH(12), .COUNT(4))
        d1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1.slave));
    approx_acc_sub #(.IGNORE_BIT(0), .WIDTH(12), .ACC_WIDTH(12), .COUNT(2))
        d2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2.slave));

    typedef struct {
        logic [11:0] d;
        logic        o;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && clear === 1'b0) begin
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) chk("d0_unexpected_result", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("d0_data", 32'(if0.out_data), 32'(e.d));
                    chk("d0_ovf", 32'(if0.out_ovf), 32'(e.o));
                end
            end
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) chk("d1_unexpected_result", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("d1_data", 32'(if1.out_data), 32'(e.d));
                    chk("d1_ovf", 32'(if1.out_ovf), 32'(e.o));
                end
            end
            if (if2.out_valid && if2.out_ready) begin
                if (q2.size() == 0) chk("d2_unexpected_result", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("d2_data", 32'(if2.out_data), 32'(e.d));
                    chk("d2_ovf", 32'(if2.out_ovf), 32'(e.o));
                end
            end
        end
    end

    task automatic push_a(input logic [11:0] e0, input logic o0, input logic [11:0] e1, input logic o1);
        q0.push_back('{d: e0, o: o0});
        q1.push_back('{d: e1, o: o1});
    endtask

    task automatic send_a(input logic [7:0] d, input logic s, input int gap);
        bit hs;
        repeat (gap) begin @(posedge clk); #1; end
        vld_a = 1'b1; dat_a = d; sub_a = s;
        hs = 1'b0;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = if0.in_ready;
            @(posedge clk); #1;
        end
        if (!hs) chk("send_a_timeout", 0, 1);
        vld_a = 1'b0;
    endtask

    task automatic send_b(input logic [11:0] d, input logic s);
        bit hs;
        vld_b = 1'b1; dat_b = d; sub_b = s;
        hs = 1'b0;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = if2.in_ready;
            @(posedge clk); #1;
        end
        if (!hs) chk("send_b_timeout", 0, 1);
        vld_b = 1'b0;
    endtask

    // Returns at the negedge where the result is presented.
    task automatic wait_out(input int which);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = (which == 0) ? if0.out_valid : if2.out_valid;
        end
        if (!seen) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic stream_a(input bit gaps);
        send_a(8'd5,   1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
        send_a(8'd3,   1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
        send_a(8'd2,   1'b1, gaps ? int'($urandom_range(0, 3)) : 0);
        send_a(8'd1,   1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        vld_a = 1'b0; sub_a = 1'b0; dat_a = '0; ordy_a = 1'b1;
        vld_b = 1'b0; sub_b = 1'b0; dat_b = '0; ordy_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(if0.in_ready), 1);
        chk("rst_out_valid", 32'(if0.out_valid), 0);
        chk("rst_out_data", 32'(if0.out_data), 0);
        chk("rst_out_ovf", 32'(if0.out_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic stream, with latency check on the 4th operand.
        push_a(12'h003, 1'b0, 12'h007, 1'b0);
        send_a(8'd5, 1'b0, 0);
        send_a(8'd3, 1'b0, 0);
        send_a(8'd2, 1'b1, 0);
        vld_a = 1'b1; dat_a = 8'd1; sub_a = 1'b0;
        @(negedge clk);
        chk("lat_before_valid", 32'(if0.out_valid), 0);
        @(posedge clk); #1;
        vld_a = 1'b0;
        @(negedge clk);
        chk("lat_after_valid_d0", 32'(if0.out_valid), 1);
        chk("lat_after_valid_d1", 32'(if1.out_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_valid_drops", 32'(if0.out_valid), 0);
        @(posedge clk); #1;

        // Same stream with random gaps.
        push_a(12'h003, 1'b0, 12'h007, 1'b0);
        stream_a(1'b1);
        wait_out(0);
        @(posedge clk); #1;

        // Backpressure in DONE with an operand offered the whole time.
        ordy_a = 1'b0;
        push_a(12'h003, 1'b0, 12'h007, 1'b0);
        stream_a(1'b0);
        wait_out(0);
        vld_a = 1'b1; dat_a = 8'h7F; sub_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_d0_data", 32'(if0.out_data), 32'h003);
            chk("bp_d1_data", 32'(if1.out_data), 32'h007);
            chk("bp_ovf", 32'(if1.out_ovf), 0);
            chk("bp_in_ready", 32'(if0.in_ready), 0);
            chk("bp_out_valid", 32'(if1.out_valid), 1);
        end
        @(posedge clk); #1;
        vld_a = 1'b0; ordy_a = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(if0.in_ready), 1);
        @(posedge clk); #1;

        // CLEAR with the 3rd operand, then four +1 operands.
        push_a(12'h003, 1'b0, 12'h004, 1'b0);
        send_a(8'd1, 1'b0, 0);
        send_a(8'd1, 1'b0, 0);
        vld_a = 1'b1; dat_a = 8'd1; sub_a = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0; clear = 1'b0;
        for (int i = 0; i < 4; i++) send_a(8'd1, 1'b0, 0);
        wait_out(0);
        @(posedge clk); #1;

        // CLEAR in DONE drops the result.
        ordy_a = 1'b0;
        for (int i = 0; i < 4; i++) send_a(8'd1, 1'b0, 0);
        wait_out(0);
        @(posedge clk); #1;
        ordy_a = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_done_valid_d0", 32'(if0.out_valid), 0);
        chk("clear_done_valid_d1", 32'(if1.out_valid), 0);
        @(posedge clk); #1;

        // Overflow config.
        q2.push_back('{d: 12'hFFE, o: 1'b1});
        q2.push_back('{d: 12'h002, o: 1'b0});
        send_b(12'h7FF, 1'b0);
        send_b(12'h7FF, 1'b0);
        wait_out(2);
        @(posedge clk); #1;
        send_b(12'h001, 1'b0);
        send_b(12'h001, 1'b0);
        wait_out(2);
        @(posedge clk); #1;

        // Asynchronous reset mid-frame.
        send_a(8'd5, 1'b0, 0);
        send_a(8'd3, 1'b0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(if0.in_ready), 1);
        chk("arst_out_valid", 32'(if1.out_valid), 0);
        chk("arst_out_data_d0", 32'(if0.out_data), 0);
        chk("arst_out_data_d1", 32'(if1.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_a(12'h003, 1'b0, 12'h007, 1'b0);
        stream_a(1'b0);
        wait_out(0);
        repeat (3) begin @(posedge clk); #1; end

        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
